// File: rtl/pd_tx_retry_ctrl_if.sv
// pd_tx_retry_ctrl_if
//   Bundles every non-clock/reset signal of the USB-PD transmit retry
//   controller.
//   master : policy engine / PHY / receiver side. Drives the request,
//            cancel, msgid_clr, line and rx inputs.
//   slave  : the controller. Drives req_rdy, phy_go, phy_sop, msgid and
//            the result.
interface pd_tx_retry_ctrl_if;
  logic       req_vld;
  logic [1:0] req_sop;
  logic       req_rdy;
  logic       cancel;
  logic       msgid_clr;
  logic       line_busy;
  logic       phy_go;
  logic [1:0] phy_sop;
  logic       phy_done;
  logic       rx_vld;
  logic       rx_crc_ok;
  logic       rx_goodcrc;
  logic [2:0] rx_msgid;
  logic [1:0] rx_sop;
  logic [2:0] msgid;
  logic       rslt_vld;
  logic [1:0] rslt_code;

  modport master (
    output req_vld, req_sop, cancel, msgid_clr, line_busy, phy_done,
           rx_vld, rx_crc_ok, rx_goodcrc, rx_msgid, rx_sop,
    input  req_rdy, phy_go, phy_sop, msgid, rslt_vld, rslt_code
  );

  modport slave (
    input  req_vld, req_sop, cancel, msgid_clr, line_busy, phy_done,
           rx_vld, rx_crc_ok, rx_goodcrc, rx_msgid, rx_sop,
    output req_rdy, phy_go, phy_sop, msgid, rslt_vld, rslt_code
  );
endinterface

// File: rtl/pd_tx_retry_ctrl.sv
// pd_tx_retry_ctrl
//   Transmit-side retry controller for USB-PD. It accepts one buffered
//   message at a time and waits for the CC line to go idle. It then starts
//   the PHY and waits tReceive for a GoodCRC. It retries up to N_RETRY
//   times and reports SUCCESS / FAIL / DISCARD / CANCEL. It also owns the
//   MessageID counter.
// Ports
//   clk  : sole clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : pd_tx_retry_ctrl_if.slave. Carries the request handshake,
//          cancel/msgid_clr, line_busy, the PHY go/sop/done signals, the
//          rx packet info, msgid and the result.
module pd_tx_retry_ctrl #(
  parameter int TRCV_CYC = 12000,
  parameter int N_RETRY  = 2
) (
  input logic              clk,
  input logic              rst,
  pd_tx_retry_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DEFER, SEND, WAIT_CRC} state_t;

  localparam logic [1:0]  RC_SUCCESS = 2'd0;
  localparam logic [1:0]  RC_FAIL    = 2'd1;
  localparam logic [1:0]  RC_DISCARD = 2'd2;
  localparam logic [1:0]  RC_CANCEL  = 2'd3;
  localparam logic [15:0] TMR_LD     = 16'(TRCV_CYC - 1);
  localparam logic [1:0]  RETRY_MAX  = 2'(N_RETRY);

  state_t      state, state_nxt;
  logic [15:0] timer;
  logic [1:0]  retry_cnt;
  logic [2:0]  msgid_q;
  logic [1:0]  phy_sop_q;
  logic        rslt_vld_q;
  logic [1:0]  rslt_code_q;

  // decisions made by the next-state logic this cycle
  logic        end_evt;
  logic [1:0]  end_code;
  logic        msgid_inc;
  logic        retry_evt;
  logic        tmr_load;

  // rx qualification; a bad-CRC packet never counts
  logic rx_ok, sop_hit, ack_hit, nack_hit;
  assign rx_ok    = bus.rx_vld & bus.rx_crc_ok;
  assign sop_hit  = (bus.rx_sop == phy_sop_q);
  assign ack_hit  = rx_ok & bus.rx_goodcrc & sop_hit & (bus.rx_msgid == msgid_q);
  assign nack_hit = rx_ok & ~bus.rx_goodcrc & sop_hit;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next state + transaction decisions; cancel outranks every other event
  always_comb begin
    state_nxt = state;
    end_evt   = 1'b0;
    end_code  = RC_SUCCESS;
    msgid_inc = 1'b0;
    retry_evt = 1'b0;
    tmr_load  = 1'b0;
    if (state != IDLE && bus.cancel) begin
      state_nxt = IDLE;
      end_evt   = 1'b1;
      end_code  = RC_CANCEL;
    end else begin
      case (state)
        IDLE:  if (bus.req_vld) state_nxt = DEFER;
        DEFER: if (!bus.line_busy) state_nxt = SEND;
        SEND:  if (bus.phy_done) begin
          state_nxt = WAIT_CRC;
          tmr_load  = 1'b1;
        end
        WAIT_CRC: begin
          // a qualifying packet wins over a timeout in the same cycle
          if (ack_hit) begin
            state_nxt = IDLE;
            end_evt   = 1'b1;
            end_code  = RC_SUCCESS;
            msgid_inc = 1'b1;
          end else if (nack_hit) begin
            state_nxt = IDLE;
            end_evt   = 1'b1;
            end_code  = RC_DISCARD;
          end else if (timer == 16'd0) begin
            if (retry_cnt < RETRY_MAX) begin
              state_nxt = DEFER;
              retry_evt = 1'b1;
            end else begin
              state_nxt = IDLE;
              end_evt   = 1'b1;
              end_code  = RC_FAIL;
              msgid_inc = 1'b1;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // outputs; phy_go fires only on the DEFER->SEND transition
  always_comb begin
    bus.req_rdy = (state == IDLE);
    bus.phy_go  = (state == DEFER) & ~bus.line_busy & ~bus.cancel & ~rst;
  end

  // datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      timer       <= '0;
      retry_cnt   <= '0;
      msgid_q     <= '0;
      phy_sop_q   <= '0;
      rslt_vld_q  <= 1'b0;
      rslt_code_q <= '0;
    end else begin
      rslt_vld_q  <= end_evt;
      rslt_code_q <= end_evt ? end_code : 2'd0;
      if (state == IDLE && bus.req_vld) begin
        phy_sop_q <= bus.req_sop;
        retry_cnt <= '0;
      end else if (retry_evt) begin
        retry_cnt <= retry_cnt + 2'd1;
      end
      if (tmr_load)
        timer <= TMR_LD;
      else if (state == WAIT_CRC && timer != 16'd0)
        timer <= timer - 16'd1;
      // clear wins over a simultaneous increment
      if (bus.msgid_clr)  msgid_q <= '0;
      else if (msgid_inc) msgid_q <= msgid_q + 3'd1;
    end
  end

  assign bus.phy_sop   = phy_sop_q;
  assign bus.msgid     = msgid_q;
  assign bus.rslt_vld  = rslt_vld_q;
  assign bus.rslt_code = rslt_code_q;

endmodule

// File: tb/tb_pd_tx_retry_ctrl.sv
module tb_pd_tx_retry_ctrl;
  localparam int TRCV = 200;
  localparam int NR   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pd_tx_retry_ctrl_if bus();

  pd_tx_retry_ctrl #(.TRCV_CYC(TRCV), .N_RETRY(NR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int go_cnt = 0;

  always @(posedge clk) if (bus.phy_go === 1'b1) go_cnt <= go_cnt + 1;

  // one cycle of stimulus plus the outputs expected in that same cycle
  typedef struct {
    int req_vld, req_sop, cancel, clr, busy, done;
    int rxv, crc, gcrc, rmid, rsop;
    int e_rdy, e_go, e_psop, e_mid, e_rv, e_rc;
  } vec_t;

  vec_t tbl[32];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", nm, act, exp);
    end
  endtask

  task automatic clr_in();
    bus.req_vld = 0; bus.req_sop = 0; bus.cancel = 0; bus.msgid_clr = 0;
    bus.line_busy = 0; bus.phy_done = 0; bus.rx_vld = 0; bus.rx_crc_ok = 0;
    bus.rx_goodcrc = 0; bus.rx_msgid = 0; bus.rx_sop = 0;
  endtask

  task automatic nxt();
    @(negedge clk);
    clr_in();
  endtask

  task automatic rx(input int crc, input int gcrc, input int mid, input int sop);
    bus.rx_vld = 1; bus.rx_crc_ok = 1'(crc); bus.rx_goodcrc = 1'(gcrc);
    bus.rx_msgid = 3'(mid); bus.rx_sop = 2'(sop);
  endtask

  task automatic chk_rslt(input string nm, input int rc, input int mid);
    chk({nm, " rslt_vld"}, 32'(bus.rslt_vld), 1);
    chk({nm, " rslt_code"}, 32'(bus.rslt_code), rc);
    chk({nm, " msgid"}, 32'(bus.msgid), mid);
  endtask

  // accept -> go -> done -> matching GoodCRC
  task automatic tx_ok(input int sop, input int cur_mid);
    nxt(); bus.req_vld = 1; bus.req_sop = 2'(sop);
    nxt(); #1 chk("ok go", 32'(bus.phy_go), 1);
    nxt(); bus.phy_done = 1;
    nxt(); rx(1, 1, cur_mid, sop);
    nxt(); #1 chk_rslt("ok", 0, (cur_mid + 1) % 8);
  endtask

  // no GoodCRC ever: NR retries, each re-deferred TRCV+1 cycles after done
  task automatic tx_timeout(input int sop, input int bad, input int cur_mid);
    int g0;
    logic early;
    nxt(); bus.req_vld = 1; bus.req_sop = 2'(sop); g0 = go_cnt;
    nxt(); #1 chk("to go0", 32'(bus.phy_go), 1);
    for (int a = 0; a <= NR; a++) begin
      nxt(); bus.phy_done = 1;
      early = 1'b0;
      for (int k = 1; k <= TRCV; k++) begin
        nxt();
        if (bad != 0 && k == 5) rx(0, 1, cur_mid, sop);
        #1 if (bus.phy_go || bus.rslt_vld) early = 1'b1;
      end
      chk("to early end", 32'(early), 0);
      nxt(); #1;
      if (a < NR) chk("to retry go", 32'(bus.phy_go), 1);
      else        chk_rslt("to fail", 1, (cur_mid + 1) % 8);
    end
    chk("to go count", 32'(go_cnt - g0), NR + 1);
  endtask

  initial begin
    int g0;
    logic bad;
    //          rv sop can clr bsy dn rxv crc gc mid rsp | rdy go psop mid rv rc
    tbl[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 1, 0, 0, 0};
    tbl[3]  = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1,   0, 0, 1, 0, 0, 0};
    tbl[4]  = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0, 0};
    tbl[5]  = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1,   0, 0, 1, 0, 0, 0};
    tbl[6]  = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0,   0, 0, 1, 0, 0, 0};
    tbl[7]  = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1,   0, 0, 1, 0, 0, 0};
    tbl[8]  = '{1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 1, 1, 1, 0};
    tbl[9]  = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0,   0, 0, 2, 1, 0, 0};
    tbl[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 2, 1, 0, 0};
    tbl[11] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0,   0, 0, 2, 1, 0, 0};
    tbl[12] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1,   0, 0, 2, 1, 0, 0};
    tbl[13] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 6, 2,   0, 0, 2, 1, 0, 0};
    tbl[14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 2, 1, 1, 2};
    tbl[15] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 2, 1, 0, 0};
    tbl[16] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 2, 1, 0, 0};
    tbl[17] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0};
    tbl[18] = '{1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 1, 3};
    tbl[19] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 3, 1, 0, 0};
    tbl[20] = '{0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0,   0, 0, 3, 1, 0, 0};
    tbl[21] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 3, 1, 1, 3};
    tbl[22] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 1, 0, 0};
    tbl[23] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 1, 0, 0};
    tbl[24] = '{0, 0, 1, 0, 0, 0, 1, 1, 1, 1, 0,   0, 0, 0, 1, 0, 0};
    tbl[25] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 1, 3};
    tbl[26] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 0, 0};
    tbl[27] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0};
    tbl[28] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0};
    tbl[29] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0};
    tbl[30] = '{0, 0, 0, 1, 0, 0, 1, 1, 1, 0, 0,   0, 0, 0, 0, 0, 0};
    tbl[31] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 1, 0};

    clr_in();
    repeat (2) @(posedge clk);

    foreach (tbl[i]) begin
      @(negedge clk);
      rst = 1'b0;
      bus.req_vld = 1'(tbl[i].req_vld); bus.req_sop = 2'(tbl[i].req_sop);
      bus.cancel = 1'(tbl[i].cancel); bus.msgid_clr = 1'(tbl[i].clr);
      bus.line_busy = 1'(tbl[i].busy); bus.phy_done = 1'(tbl[i].done);
      bus.rx_vld = 1'(tbl[i].rxv); bus.rx_crc_ok = 1'(tbl[i].crc);
      bus.rx_goodcrc = 1'(tbl[i].gcrc); bus.rx_msgid = 3'(tbl[i].rmid);
      bus.rx_sop = 2'(tbl[i].rsop);
      #1;
      chk($sformatf("v%0d req_rdy", i), 32'(bus.req_rdy), tbl[i].e_rdy);
      chk($sformatf("v%0d phy_go", i), 32'(bus.phy_go), tbl[i].e_go);
      chk($sformatf("v%0d phy_sop", i), 32'(bus.phy_sop), tbl[i].e_psop);
      chk($sformatf("v%0d msgid", i), 32'(bus.msgid), tbl[i].e_mid);
      chk($sformatf("v%0d rslt_vld", i), 32'(bus.rslt_vld), tbl[i].e_rv);
      chk($sformatf("v%0d rslt_code", i), 32'(bus.rslt_code), tbl[i].e_rc);
    end

    // GoodCRC 100 cycles after phy_done
    nxt(); bus.req_vld = 1; bus.req_sop = 0; g0 = go_cnt;
    nxt(); #1 chk("h1 go", 32'(bus.phy_go), 1);
    nxt(); bus.phy_done = 1;
    repeat (99) nxt();
    nxt(); rx(1, 1, 0, 0);
    nxt(); #1 chk_rslt("h1", 0, 1);
    chk("h1 go count", 32'(go_cnt - g0), 1);

    // no response at all
    tx_timeout(1, 0, 1);

    // wrong msgid ignored, then matching GoodCRC
    nxt(); bus.req_vld = 1; bus.req_sop = 0;
    nxt(); #1 chk("h3 go", 32'(bus.phy_go), 1);
    nxt(); bus.phy_done = 1;
    repeat (3) nxt();
    nxt(); rx(1, 1, 5, 0);
    nxt(); #1 chk("h3 wrong id ignored", 32'(bus.rslt_vld), 0);
    rx(1, 1, 2, 0);
    nxt(); #1 chk_rslt("h3", 0, 3);

    // bad-CRC GoodCRC ignored -> timeout path
    tx_timeout(0, 1, 3);

    // line busy 50 cycles from accept, then cancel during SEND
    nxt(); bus.req_vld = 1; bus.req_sop = 2; bus.line_busy = 1; g0 = go_cnt;
    bad = 1'b0;
    for (int i = 1; i < 50; i++) begin
      nxt(); bus.line_busy = 1;
      #1 if (bus.phy_go) bad = 1'b1;
    end
    chk("h4 go while busy", 32'(bad), 0);
    nxt(); #1 chk("h4 go after busy", 32'(bus.phy_go), 1);
    nxt(); bus.cancel = 1;
    nxt(); #1 chk_rslt("h4 cancel", 3, 4);
    chk("h4 go count", 32'(go_cnt - g0), 1);

    // msgid wrap 7 -> 0
    tx_ok(0, 4);
    tx_ok(1, 5);
    tx_ok(2, 6);
    tx_ok(0, 7);

    // reset mid-transaction: no result, everything cleared
    nxt(); bus.req_vld = 1; bus.req_sop = 1;
    nxt();
    nxt(); rst = 1'b1; bus.phy_done = 1;
    nxt(); rst = 1'b0;
    #1;
    chk("rst req_rdy", 32'(bus.req_rdy), 1);
    chk("rst rslt_vld", 32'(bus.rslt_vld), 0);
    chk("rst phy_sop", 32'(bus.phy_sop), 0);
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      nxt(); rx(1, 1, 0, 1);
      #1 if (bus.rslt_vld || !bus.req_rdy) bad = 1'b1;
    end
    chk("rst no result", 32'(bad), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
